// File: rtl/dlfloat_mult_arbiter.sv
// rtl/dlfloat_mult_arbiter.sv - round-robin front end sharing one registered DLFloat16 multiplier
//
// Purpose: arbitrates NREQ requesters onto a single multiplier, registers the operands,
// tracks each in-flight op with a tag pipe and steers the product back to its issuer.
//
// Ports:
//   clk, rst_n            clock (posedge), async active-low reset
//   req_valid/req_ready   per-requester request handshake (req_ready is a one-hot grant)
//   req_a, req_b          per-requester operands, requester i at [16*i +: 16]
//   mul_a, mul_b          registered operands to the multiplier
//   mul_c                 product returned by the multiplier, MUL_LAT clocks after mul_a/mul_b
//   rsp_valid/rsp_ready   per-requester response handshake
//   rsp_data              held product of requester i at [16*i +: 16]
//   rsp_nan               held product of requester i is the NaN pattern 16'hFFFF
//   issue_cnt             free-running count of issued ops

module dlfloat_mult_arbiter #(
    parameter int NREQ    = 4,
    parameter int MUL_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*16-1:0]   req_a,
    input  logic [NREQ*16-1:0]   req_b,
    output logic [15:0]          mul_a,
    output logic [15:0]          mul_b,
    input  logic [15:0]          mul_c,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [NREQ*16-1:0]   rsp_data,
    output logic [NREQ-1:0]      rsp_nan,
    output logic [15:0]          issue_cnt
);

    localparam int IDW = $clog2(NREQ);
    localparam int NST = MUL_LAT + 1;

    logic [NREQ-1:0]           busy;
    logic [IDW-1:0]            ptr;
    logic [NREQ-1:0]           elig;
    logic [NREQ-1:0]           grant;
    logic [IDW-1:0]            grant_id;
    logic                      found;
    int                        idx;

    logic [NST-1:0]            tag_v;
    logic [NST-1:0][IDW-1:0]   tag_id;
    logic                      ret_v;
    logic [IDW-1:0]            ret_id;

    // busy is registered, so a requester whose response is accepted this cycle
    // only becomes eligible again next cycle.
    assign elig = req_valid & ~busy;

    // Round-robin search starting at ptr; first eligible requester wins.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = 0;
        for (int o = 0; o < NREQ; o++) begin
            idx = (int'(ptr) + o) % NREQ;
            if (!found && elig[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_id   = IDW'(idx);
            end
        end
    end

    assign req_ready = rst_n ? grant : '0;

    assign ret_v  = tag_v[NST-1];
    assign ret_id = tag_id[NST-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            mul_a     <= '0;
            mul_b     <= '0;
            issue_cnt <= '0;
            tag_v     <= '0;
            tag_id    <= '0;
        end else begin
            tag_v[0]  <= found;
            tag_id[0] <= grant_id;
            for (int s = 1; s < NST; s++) begin
                tag_v[s]  <= tag_v[s-1];
                tag_id[s] <= tag_id[s-1];
            end
            if (found) begin
                ptr       <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
                mul_a     <= req_a[16*grant_id +: 16];
                mul_b     <= req_b[16*grant_id +: 16];
                issue_cnt <= issue_cnt + 16'd1;
            end
        end
    end

    // One op outstanding-or-held per requester guarantees the response slot is
    // free when the tagged product comes back, so a return never collides.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy      <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (grant[i]) begin
                    busy[i] <= 1'b1;
                end else if (rsp_valid[i] && rsp_ready[i]) begin
                    busy[i] <= 1'b0;
                end
                if (ret_v && ret_id == IDW'(i)) begin
                    rsp_valid[i]          <= 1'b1;
                    rsp_data[16*i +: 16]  <= mul_c;
                end else if (rsp_ready[i]) begin
                    rsp_valid[i] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        rsp_nan = '0;
        for (int i = 0; i < NREQ; i++) begin
            rsp_nan[i] = (rsp_data[16*i +: 16] == 16'hFFFF);
        end
    end

endmodule

// File: tb/tb_dlfloat_mult_arbiter.sv
// tb/tb_dlfloat_mult_arbiter.sv - self-checking bench for dlfloat_mult_arbiter

module tb_dlfloat_mult_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [15:0] mul_a;
    logic [15:0] mul_b;
    logic [15:0] mul_c;
    logic [3:0]  rsp_valid;
    logic [3:0]  rsp_ready;
    logic [63:0] rsp_data;
    logic [3:0]  rsp_nan;
    logic [15:0] issue_cnt;

    dlfloat_mult_arbiter #(.NREQ(4), .MUL_LAT(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_c     (mul_c),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_nan   (rsp_nan),
        .issue_cnt (issue_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference DLFloat16 multiply (1s/6e/9m, bias 31, truncating).
    function automatic logic [15:0] dl_mul(input logic [15:0] a, input logic [15:0] b);
        logic [19:0] p;
        int          e;
        logic        s;
        logic [8:0]  m;
        if (a == 16'hFFFF || b == 16'hFFFF) return 16'hFFFF;
        s = a[15] ^ b[15];
        if (a[14:9] == 6'd0 || b[14:9] == 6'd0) return {s, 15'd0};
        p = {1'b1, a[8:0]} * {1'b1, b[8:0]};
        e = int'(a[14:9]) + int'(b[14:9]) - 31;
        if (p[19]) begin
            m = p[18:10];
            e++;
        end else begin
            m = p[17:9];
        end
        if (e >= 63) return 16'hFFFF;
        if (e <= 0) return {s, 15'd0};
        return {s, e[5:0], m};
    endfunction

    // One-cycle registered multiplier model.
    initial mul_c = 16'h0000;
    always @(posedge clk) mul_c <= dl_mul(mul_a, mul_b);

    typedef struct {
        int          id;
        logic [15:0] data;
    } sb_t;

    sb_t         sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          issued = 0;
    int          m_ptr = 0;
    logic [3:0]  m_busy = '0;
    logic [3:0]  prev_rv = '0;
    logic [3:0]  prev_rr = '0;
    logic [15:0] prev_data [4];
    int          grant_cyc [4];
    logic [3:0]  last_ready = '0;

    task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        issued  = 0;
        m_ptr   = 0;
        m_busy  = '0;
        prev_rv = '0;
        prev_rr = '0;
    endtask

    // Per-cycle scoreboard, run at the negedge with this cycle's inputs stable.
    task automatic monitor();
        logic [3:0] elig;
        logic [3:0] exp_gnt;
        int         k;
        int         hit;
        last_ready = req_ready;
        if (!rst_n) begin
            model_reset();
            check4("ready_in_reset", req_ready, 4'b0000);
            return;
        end
        check16("issue_cnt", issue_cnt, issued[15:0]);
        elig    = req_valid & ~m_busy;
        exp_gnt = '0;
        for (int o = 0; o < 4; o++) begin
            k = (m_ptr + o) % 4;
            if (exp_gnt == 4'b0000 && elig[k]) exp_gnt[k] = 1'b1;
        end
        check4("grant", req_ready, exp_gnt);
        for (int i = 0; i < 4; i++) begin
            hit = -1;
            for (int j = 0; j < sb.size(); j++) begin
                if (hit < 0 && sb[j].id == i) hit = j;
            end
            if (rsp_valid[i] && !prev_rv[i]) begin
                check_int("rsp_latency", cyc - grant_cyc[i], 3);
                check_int("rsp_expected", (hit >= 0) ? 1 : 0, 1);
            end
            if (rsp_valid[i] && prev_rv[i] && !prev_rr[i])
                check16("rsp_hold", rsp_data[16*i +: 16], prev_data[i]);
            if (rsp_valid[i])
                check4("rsp_nan", {3'b000, rsp_nan[i]},
                       {3'b000, rsp_data[16*i +: 16] == 16'hFFFF});
            if (rsp_valid[i] && rsp_ready[i]) begin
                m_busy[i] = 1'b0;
                if (hit >= 0) begin
                    check16("rsp_data", rsp_data[16*i +: 16], sb[hit].data);
                    sb.delete(hit);
                end
            end
            prev_rv[i]   = rsp_valid[i];
            prev_rr[i]   = rsp_ready[i];
            prev_data[i] = rsp_data[16*i +: 16];
        end
        for (int i = 0; i < 4; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                sb.push_back('{i, dl_mul(req_a[16*i +: 16], req_b[16*i +: 16])});
                m_busy[i]    = 1'b1;
                grant_cyc[i] = cyc;
                issued++;
                m_ptr = (i + 1) % 4;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic reset_dut();
        rst_n     = 1'b0;
        req_valid = '0;
        tick();
        tick();
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic wait_rsp(input int i);
        for (int w = 0; w < 8; w++) begin
            if (rsp_valid[i]) break;
            tick();
        end
        check4("rsp_timeout", {3'b000, rsp_valid[i]}, 4'b0001);
    endtask

    int g1;
    int go;
    logic [15:0] held;

    initial begin
        rst_n     = 1'b0;
        req_valid = 4'hF;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 4'hF;
        #1;
        check4("reset_ready", req_ready, 4'b0000);
        check4("reset_rsp_valid", rsp_valid, 4'b0000);
        check16("reset_issue_cnt", issue_cnt, 16'h0000);
        check16("reset_mul_a", mul_a, 16'h0000);
        check16("reset_mul_b", mul_b, 16'h0000);
        reset_dut();

        // Single op: 1.0 * 2.0
        req_a[15:0] = 16'h3E00;
        req_b[15:0] = 16'h4000;
        req_valid   = 4'b0001;
        tick();
        req_valid = 4'b0000;
        wait_rsp(0);
        check16("single_data", rsp_data[15:0], 16'h4000);
        check4("single_nan", rsp_nan, 4'b0000);
        check16("single_cnt", issue_cnt, 16'h0001);
        for (int n = 0; n < 4; n++) tick();

        // Contention from reset
        reset_dut();
        req_a     = {16'h4400, 16'h4200, 16'h4000, 16'h3E00};
        req_b     = {16'h3F00, 16'h4100, 16'h4000, 16'h4200};
        req_valid = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            tick();
            check4("rr_order", last_ready, 4'b0001 << k);
        end
        for (int n = 0; n < 8; n++) tick();

        // Back-pressure on requester 1
        rsp_ready = 4'b1101;
        for (int n = 0; n < 8; n++) tick();
        check4("bp_held", {3'b000, rsp_valid[1]}, 4'b0001);
        held = rsp_data[31:16];
        g1 = 0;
        go = 0;
        for (int n = 0; n < 12; n++) begin
            tick();
            if (last_ready[1]) g1++;
            if (last_ready[0] || last_ready[2] || last_ready[3]) go++;
        end
        check_int("bp_no_grant1", g1, 0);
        check_int("bp_others_rotate", (go >= 8) ? 1 : 0, 1);
        check16("bp_data_stable", rsp_data[31:16], held);
        rsp_ready = 4'b1111;
        tick();
        check4("bp_accept_no_grant", {3'b000, last_ready[1]}, 4'b0000);
        for (int n = 0; n < 8; n++) tick();
        req_valid = 4'b0000;
        for (int n = 0; n < 8; n++) tick();

        // Specials: NaN and zero
        rsp_ready   = 4'b1110;
        req_a[15:0] = 16'hFFFF;
        req_b[15:0] = 16'h3E00;
        req_valid   = 4'b0001;
        tick();
        req_valid = 4'b0000;
        wait_rsp(0);
        check16("nan_data", rsp_data[15:0], 16'hFFFF);
        check4("nan_flag", {3'b000, rsp_nan[0]}, 4'b0001);
        rsp_ready = 4'b1111;
        tick();
        rsp_ready    = 4'b1011;
        req_a[47:32] = 16'h0000;
        req_b[47:32] = 16'h4200;
        req_valid    = 4'b0100;
        tick();
        req_valid = 4'b0000;
        wait_rsp(2);
        check16("zero_data", rsp_data[47:32], 16'h0000);
        check4("zero_flag", {3'b000, rsp_nan[2]}, 4'b0000);
        rsp_ready = 4'b1111;
        for (int n = 0; n < 4; n++) tick();

        // Reset mid-flight
        req_valid = 4'b1100;
        tick();
        tick();
        req_valid = 4'b0000;
        rst_n     = 1'b0;
        #1;
        check4("rst_mid_rsp_valid", rsp_valid, 4'b0000);
        check16("rst_mid_issue_cnt", issue_cnt, 16'h0000);
        model_reset();
        tick();
        rst_n = 1'b1;
        for (int n = 0; n < 10; n++) begin
            tick();
            check4("rst_no_rsp", rsp_valid, 4'b0000);
        end

        // Counter wrap
        reset_dut();
        rsp_ready = 4'b1111;
        req_valid = 4'b1111;
        for (int n = 0; n < 70000; n++) begin
            if (issued >= 65536) break;
            req_a = {$urandom, $urandom};
            req_b = {$urandom, $urandom};
            tick();
        end
        req_valid = 4'b0000;
        check_int("wrap_issued", issued, 65536);
        check16("wrap_cnt", issue_cnt, 16'h0000);
        for (int n = 0; n < 8; n++) tick();
        req_a[63:48] = 16'h3E00;
        req_b[63:48] = 16'h3E00;
        req_valid    = 4'b1000;
        tick();
        check4("wrap_grant", last_ready, 4'b1000);
        req_valid = 4'b0000;
        wait_rsp(3);
        check16("wrap_data", rsp_data[63:48], 16'h3E00);
        for (int n = 0; n < 4; n++) tick();
        check_int("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
